md_issue: RTL

MD_ISSUE -- requirements
Module: md_issue

---
 rtl/md_issue.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/md_issue.sv
// md_issue -- EX-stage issue controller for the multiply/divide unit.
//
// Decodes HI/LO instructions in EX, registers the operation and its operands
// for the mul/div unit, and freezes the front of the pipe while a long op
// (DIV/DIVU/MULT/MULTU/MUL) occupies the unit.
//
// Ports:
//   Clk          single clock, rising edge
//   Rst_n        asynchronous active-low reset
//   Ex_valid     EX-stage instruction valid
//   Instr_op     opcode field [31:26]
//   Instr_funct  funct field [5:0]
//   Rs_val       forwarded rs operand
//   Rt_val       forwarded rt operand
//   Flush        squash the EX instruction (only honoured in IDLE)
//   Md_stall     busy flag returned by the mul/div unit
//   Md_op        registered op code to the unit
//   Rs_out       registered rs to the unit
//   Rt_out       registered rt to the unit
//   Pipe_stall   freeze IF/ID/EX (combinational)
//   Md_timeout   one-cycle pulse when BUSY is forced to complete
//
// Parameter MAX_CYCLES (2..255): BUSY-cycle limit before forced completion.
// Optional feature: define MD_MUL_EN to decode SPECIAL2 MUL (op 011100,
// funct 000010) as the long op 0111.
module md_issue #(
  parameter int MAX_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Ex_valid,
  input  logic [5:0]  Instr_op,
  input  logic [5:0]  Instr_funct,
  input  logic [31:0] Rs_val,
  input  logic [31:0] Rt_val,
  input  logic        Flush,
  input  logic        Md_stall,
  output logic [3:0]  Md_op,
  output logic [31:0] Rs_out,
  output logic [31:0] Rt_out,
  output logic        Pipe_stall,
  output logic        Md_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  md_op_reg, md_op_next;
  logic [31:0] rs_reg, rs_next;
  logic [31:0] rt_reg, rt_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        timeout_reg, timeout_next;

  logic [3:0]  dec_op;
  logic        dec_long;
  logic        dec_short;
  logic        issue_ok;

  // Instruction decode
  always_comb begin
    dec_op = 4'b0000;
    if (Instr_op == 6'b000000) begin
      case (Instr_funct)
        6'b011010: dec_op = 4'b0001; // DIV
        6'b011011: dec_op = 4'b0010; // DIVU
        6'b010000: dec_op = 4'b0011; // MFHI
        6'b010010: dec_op = 4'b0100; // MFLO
        6'b010001: dec_op = 4'b0101; // MTHI
        6'b010011: dec_op = 4'b0110; // MTLO
        6'b011000: dec_op = 4'b1000; // MULT
        6'b011001: dec_op = 4'b1001; // MULTU
        default:   dec_op = 4'b0000;
      endcase
    end
`ifdef MD_MUL_EN
    else if (Instr_op == 6'b011100 && Instr_funct == 6'b000010) begin
      dec_op = 4'b0111;              // MUL
    end
`endif
  end

  assign dec_long  = (dec_op == 4'b0001) || (dec_op == 4'b0010) ||
                     (dec_op == 4'b0111) || (dec_op == 4'b1000) ||
                     (dec_op == 4'b1001);
  assign dec_short = (dec_op >= 4'b0011) && (dec_op <= 4'b0110);
  assign issue_ok  = Ex_valid && !Flush;

  // Next-state and outputs
  always_comb begin
    state_next   = state_reg;
    md_op_next   = md_op_reg;
    rs_next      = rs_reg;
    rt_next      = rt_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    Pipe_stall   = 1'b0;

    case (state_reg)
      IDLE: begin
        md_op_next = 4'b0000;
        if (issue_ok && dec_long) begin
          Pipe_stall = 1'b1;
          md_op_next = dec_op;
          rs_next    = Rs_val;
          rt_next    = Rt_val;
          cnt_next   = 8'd0;
          state_next = BUSY;
        end else if (issue_ok && dec_short) begin
          // Short ops are presented for a single cycle; no stall needed.
          md_op_next = dec_op;
          rs_next    = Rs_val;
          rt_next    = Rt_val;
        end
      end
      BUSY: begin
        // Flush is ignored here: a HI/LO update is never aborted.
        Pipe_stall = 1'b1;
        cnt_next   = cnt_reg + 8'd1;
        if (!Md_stall) begin
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: begin
        // Result-capture cycle; issue is refused so the unit sees a 0000
        // cycle before the next long op.
        md_op_next = 4'b0000;
        state_next = IDLE;
      end
      default: begin
        md_op_next = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg   <= IDLE;
      md_op_reg   <= 4'b0000;
      rs_reg      <= 32'd0;
      rt_reg      <= 32'd0;
      cnt_reg     <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      md_op_reg   <= md_op_next;
      rs_reg      <= rs_next;
      rt_reg      <= rt_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign Md_op      = md_op_reg;
  assign Rs_out     = rs_reg;
  assign Rt_out     = rt_reg;
  assign Md_timeout = timeout_reg;

endmodule
